// File: rtl/stall_sequencer_if.sv
// rtl/stall_sequencer_if.sv - instruction/stall handshake bundle for stall_sequencer
interface stall_sequencer_if #(
   parameter int CNT_W = 8
) ();
   logic [19:0]      ins_pm;
   logic             resume;
   logic             cnt_clr;
   logic             stall;
   logic             pc_en;
   logic             stall_pm;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output ins_pm, resume, cnt_clr,
      input  stall, pc_en, stall_pm, halted, stall_cnt
   );

   modport slave (
      input  ins_pm, resume, cnt_clr,
      output stall, pc_en, stall_pm, halted, stall_cnt
   );
endinterface

// File: rtl/stall_sequencer.sv
// rtl/stall_sequencer.sv - pipeline stall sequencer for LD, jump and halt opcodes
// with a registered stall echo and a saturating stall-cycle counter.
module stall_sequencer #(
   parameter int LD_STALL  = 1,
   parameter int JMP_STALL = 2,
   parameter int CNT_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   stall_sequencer_if.slave   bus
);
   typedef enum logic [1:0] {S_RUN, S_WAIT, S_ISSUE, S_HALT} state_t;

   localparam logic [4:0]       OP_HLT   = 5'b10001;
   localparam logic [4:0]       OP_LD    = 5'b10100;
   localparam logic [3:0]       LD_LOAD  = 4'((LD_STALL  >= 2) ? LD_STALL  - 2 : 0);
   localparam logic [3:0]       JMP_LOAD = 4'((JMP_STALL >= 2) ? JMP_STALL - 2 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state, state_n;
   logic [3:0]       wcnt, wcnt_n;
   logic             stall;
   logic             stall_pm;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       opcode;
   logic             unused_operand;

   assign opcode         = bus.ins_pm[19:15];
   assign unused_operand = ^bus.ins_pm[14:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_RUN;
         wcnt     <= 4'd0;
         stall_pm <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_n;
         wcnt     <= wcnt_n;
         stall_pm <= stall;
         if (bus.cnt_clr)
            cnt <= '0;
         else if (stall && (cnt != CNT_MAX))
            cnt <= cnt + CNT_W'(1);
      end
   end

   // The decode cycle is the first stall cycle, so WAIT is loaded with N-2.
   always_comb begin
      state_n = state;
      wcnt_n  = wcnt;
      stall   = 1'b0;
      unique case (state)
         S_RUN: begin
            if (opcode == OP_HLT) begin
               stall   = 1'b1;
               state_n = S_HALT;
            end else if (opcode == OP_LD) begin
               stall = 1'b1;
               if (LD_STALL <= 1) begin
                  state_n = S_ISSUE;
               end else begin
                  state_n = S_WAIT;
                  wcnt_n  = LD_LOAD;
               end
            end else if (opcode[4:2] == 3'b111) begin
               stall = 1'b1;
               if (JMP_STALL <= 1) begin
                  state_n = S_ISSUE;
               end else begin
                  state_n = S_WAIT;
                  wcnt_n  = JMP_LOAD;
               end
            end
         end
         S_WAIT: begin
            stall = 1'b1;
            if (wcnt == 4'd0)
               state_n = S_ISSUE;
            else
               wcnt_n = wcnt - 4'd1;
         end
         S_ISSUE: begin
            state_n = S_RUN;
         end
         S_HALT: begin
            stall = 1'b1;
            if (bus.resume)
               state_n = S_ISSUE;
         end
         default: begin
            state_n = S_RUN;
         end
      endcase
   end

   assign bus.stall     = stall;
   assign bus.pc_en     = ~stall;
   assign bus.stall_pm  = stall_pm;
   assign bus.halted    = (state == S_HALT);
   assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_stall_sequencer.sv
// tb/tb_stall_sequencer.sv - bench for stall_sequencer: default instance and
// a JMP_STALL=4 / LD_STALL=3 / CNT_W=3 instance driven by the same stimulus.
module tb_stall_sequencer;
   localparam logic [4:0] OP_NOP = 5'b00000;
   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_LD  = 5'b10100;
   localparam logic [4:0] OP_HLT = 5'b10001;
   localparam logic [4:0] OP_JMP = 5'b11100;

   typedef struct {
      int left;
      bit halt;
      bit issue;
      int cnt;
      bit pm;
   } mdl_t;

   logic        clk     = 1'b0;
   logic        reset   = 1'b0;
   logic [19:0] ins_pm  = 20'd0;
   logic        resume  = 1'b0;
   logic        cnt_clr = 1'b0;
   bit          chk_en  = 1'b1;
   int          checks  = 0;
   int          errors  = 0;
   mdl_t        ma      = '{0, 1'b0, 1'b0, 0, 1'b0};
   mdl_t        mb      = '{0, 1'b0, 1'b0, 0, 1'b0};

   stall_sequencer_if #(.CNT_W(8)) bus_a ();
   stall_sequencer_if #(.CNT_W(3)) bus_b ();

   assign bus_a.ins_pm  = ins_pm;
   assign bus_a.resume  = resume;
   assign bus_a.cnt_clr = cnt_clr;
   assign bus_b.ins_pm  = ins_pm;
   assign bus_b.resume  = resume;
   assign bus_b.cnt_clr = cnt_clr;

   stall_sequencer dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   stall_sequencer #(.LD_STALL(3), .JMP_STALL(4), .CNT_W(3)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   function automatic bit is_stall_op(input logic [4:0] op);
      return (op == OP_HLT) || (op == OP_LD) || (op[4:2] == 3'b111);
   endfunction

   // Stall is owed while a pending stall budget or a halt is outstanding,
   // never in the single issue cycle, otherwise it is the opcode's class.
   function automatic bit m_stall(input mdl_t m, input logic [19:0] ins);
      if (m.issue)    return 1'b0;
      if (m.left > 0) return 1'b1;
      if (m.halt)     return 1'b1;
      return is_stall_op(ins[19:15]);
   endfunction

   function automatic mdl_t m_next(input mdl_t m, input logic [19:0] ins,
                                   input logic res, input logic clr,
                                   input int ld, input int jmp, input int cmax);
      mdl_t n;
      bit   s;
      logic [4:0] op;
      n  = m;
      s  = m_stall(m, ins);
      op = ins[19:15];
      n.pm  = s;
      n.cnt = clr ? 0 : ((s && m.cnt < cmax) ? m.cnt + 1 : m.cnt);
      if (m.issue) begin
         n.issue = 1'b0;
      end else if (m.left > 0) begin
         n.left = m.left - 1;
         if (n.left == 0) n.issue = 1'b1;
      end else if (m.halt) begin
         if (res) begin
            n.halt  = 1'b0;
            n.issue = 1'b1;
         end
      end else if (op == OP_HLT) begin
         n.halt = 1'b1;
      end else if (op == OP_LD || op[4:2] == 3'b111) begin
         n.left = ((op == OP_LD) ? ld : jmp) - 1;
         if (n.left == 0) n.issue = 1'b1;
      end
      return n;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ma = '{0, 1'b0, 1'b0, 0, 1'b0};
         mb = '{0, 1'b0, 1'b0, 0, 1'b0};
      end else begin
         ma = m_next(ma, ins_pm, resume, cnt_clr, 1, 2, 255);
         mb = m_next(mb, ins_pm, resume, cnt_clr, 3, 4, 7);
      end
   end

   always @(negedge clk) begin
      bit ea, eb;
      if (chk_en) begin
         ea = m_stall(ma, ins_pm);
         eb = m_stall(mb, ins_pm);
         cmp("m_a_stall",    32'(bus_a.stall),     32'(ea));
         cmp("m_a_pc_en",    32'(bus_a.pc_en),     32'(!ea));
         cmp("m_a_stall_pm", 32'(bus_a.stall_pm),  32'(ma.pm));
         cmp("m_a_halted",   32'(bus_a.halted),    32'(ma.halt));
         cmp("m_a_cnt",      32'(bus_a.stall_cnt), 32'(ma.cnt));
         cmp("m_b_stall",    32'(bus_b.stall),     32'(eb));
         cmp("m_b_pc_en",    32'(bus_b.pc_en),     32'(!eb));
         cmp("m_b_stall_pm", 32'(bus_b.stall_pm),  32'(mb.pm));
         cmp("m_b_halted",   32'(bus_b.halted),    32'(mb.halt));
         cmp("m_b_cnt",      32'(bus_b.stall_cnt), 32'(mb.cnt));
      end
   end

   task automatic setin(input logic [4:0] op, input logic res, input logic clr);
      ins_pm  = {op, 15'(op * 7 + 3)};
      resume  = res;
      cnt_clr = clr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic do_reset();
      step();
      reset = 1'b0;
      setin(OP_NOP, 1'b0, 1'b0);
      repeat (2) step();
      reset = 1'b1;
   endtask

   typedef struct { logic [4:0] op; logic res; logic clr; } vec_t;
   vec_t vecs[$];

   initial begin
      setin(OP_NOP, 1'b0, 1'b0);
      repeat (3) step();
      reset = 1'b1;
      neg();
      cmp("rst_a_cnt", 32'(bus_a.stall_cnt), 32'd0);
      cmp("rst_a_halted", 32'(bus_a.halted), 32'd0);

      // LD with default LD_STALL=1
      do_reset();
      setin(OP_LD, 1'b0, 1'b0);
      neg();
      cmp("ld_stall0", 32'(bus_a.stall), 32'd1);
      cmp("ld_pc_en0", 32'(bus_a.pc_en), 32'd0);
      cmp("ld_pm0", 32'(bus_a.stall_pm), 32'd0);
      step(); neg();
      cmp("ld_stall1", 32'(bus_a.stall), 32'd0);
      cmp("ld_pc_en1", 32'(bus_a.pc_en), 32'd1);
      cmp("ld_pm1", 32'(bus_a.stall_pm), 32'd1);
      step(); setin(OP_NOP, 1'b0, 1'b0); neg();
      cmp("ld_pm2", 32'(bus_a.stall_pm), 32'd0);
      cmp("ld_cnt", 32'(bus_a.stall_cnt), 32'd1);

      // JMP with default JMP_STALL=2
      do_reset();
      setin(OP_JMP, 1'b0, 1'b0);
      neg(); cmp("jmp_stall0", 32'(bus_a.stall), 32'd1);
      step(); neg(); cmp("jmp_stall1", 32'(bus_a.stall), 32'd1);
      step(); neg(); cmp("jmp_stall2", 32'(bus_a.stall), 32'd0);
      step(); setin(OP_NOP, 1'b0, 1'b0); neg();
      cmp("jmp_stall3", 32'(bus_a.stall), 32'd0);
      cmp("jmp_cnt", 32'(bus_a.stall_cnt), 32'd2);

      // HLT held, resume sampled on the 5th edge
      do_reset();
      setin(OP_HLT, 1'b0, 1'b0);
      neg();
      cmp("hlt_stall1", 32'(bus_a.stall), 32'd1);
      cmp("hlt_halted1", 32'(bus_a.halted), 32'd0);
      for (int k = 2; k <= 4; k++) begin
         step(); neg();
         cmp("hlt_stall_mid", 32'(bus_a.stall), 32'd1);
         cmp("hlt_halted_mid", 32'(bus_a.halted), 32'd1);
      end
      step(); resume = 1'b1; neg();
      cmp("hlt_halted5", 32'(bus_a.halted), 32'd1);
      step(); setin(OP_LD, 1'b0, 1'b0); neg();
      cmp("hlt_issue_stall", 32'(bus_a.stall), 32'd0);
      cmp("hlt_issue_halted", 32'(bus_a.halted), 32'd0);
      step(); neg();
      cmp("hlt_redecode", 32'(bus_a.stall), 32'd1);
      step(); setin(OP_NOP, 1'b0, 1'b0); neg();
      cmp("hlt_cnt", 32'(bus_a.stall_cnt), 32'd6);

      // JMP_STALL=4, reset asserted in the 2nd WAIT cycle
      do_reset();
      setin(OP_JMP, 1'b0, 1'b0);
      step(); step();
      #1 reset = 1'b0;
      #1;
      cmp("rj_halted", 32'(bus_b.halted), 32'd0);
      cmp("rj_cnt", 32'(bus_b.stall_cnt), 32'd0);
      cmp("rj_pm", 32'(bus_b.stall_pm), 32'd0);
      cmp("rj_stall", 32'(bus_b.stall), 32'd1);
      step(); reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         neg(); cmp("rj_restall", 32'(bus_b.stall), 32'd1);
         step();
      end
      neg();
      cmp("rj_issue", 32'(bus_b.stall), 32'd0);
      cmp("rj_cnt4", 32'(bus_b.stall_cnt), 32'd4);
      step(); setin(OP_NOP, 1'b0, 1'b0);

      // CNT_W=3 saturation and clear-over-increment
      do_reset();
      setin(OP_HLT, 1'b0, 1'b0);
      repeat (10) step();
      neg();
      cmp("sat_cnt", 32'(bus_b.stall_cnt), 32'd7);
      cmp("sat_halted", 32'(bus_b.halted), 32'd1);
      step(); cnt_clr = 1'b1;
      step(); cnt_clr = 1'b0; neg();
      cmp("clr_cnt", 32'(bus_b.stall_cnt), 32'd0);
      step(); neg();
      cmp("clr_cnt_inc", 32'(bus_b.stall_cnt), 32'd1);
      step(); resume = 1'b1;
      step(); resume = 1'b0; neg();
      cmp("sat_issue", 32'(bus_b.stall), 32'd0);
      step(); setin(OP_NOP, 1'b0, 1'b0);

      // back-to-back and resume-outside-HALT vectors, checked by the model
      do_reset();
      vecs = '{'{OP_JMP, 1'b0, 1'b0}, '{OP_JMP, 1'b1, 1'b0}, '{OP_JMP, 1'b0, 1'b0},
               '{OP_LD, 1'b0, 1'b0},  '{OP_LD, 1'b1, 1'b0},  '{OP_LD, 1'b0, 1'b0},
               '{OP_LD, 1'b0, 1'b0},  '{OP_HLT, 1'b0, 1'b0}, '{OP_HLT, 1'b0, 1'b1},
               '{OP_HLT, 1'b1, 1'b0}, '{OP_JMP, 1'b0, 1'b0}, '{5'b11111, 1'b0, 1'b0},
               '{5'b11101, 1'b0, 1'b0}, '{OP_ADD, 1'b1, 1'b0}, '{5'b10000, 1'b0, 1'b0},
               '{5'b10101, 1'b0, 1'b0}, '{OP_NOP, 1'b0, 1'b0}};
      foreach (vecs[i]) begin
         setin(vecs[i].op, vecs[i].res, vecs[i].clr);
         step();
      end
      for (int i = 0; i < 300; i++) begin
         logic [4:0] ops[8];
         ops = '{OP_NOP, OP_ADD, OP_LD, OP_HLT, OP_JMP, 5'b11110, 5'b10000, 5'b10001};
         setin(ops[$urandom_range(0, 7)], ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 15) == 0));
         step();
      end
      neg();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
